// File: rtl/bcd_mux.sv
// Binary (0-9999, saturating) to 4-digit BCD with time-multiplexed digit bus; outputs registered, 2-clock number-to-digit latency.
// Define BCD_MUX_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit_select = 4'b1111 in those slots).
module bcd_mux #(
  parameter int REFRESH_OVERFLOW = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] number,
  output logic [3:0]  output_number,
  output logic [3:0]  digit_select
);

  localparam int CW = (REFRESH_OVERFLOW > 1) ? $clog2(REFRESH_OVERFLOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_OVERFLOW - 1);

  logic [13:0]   r_number_q;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic [13:0] w_sat;
  logic [29:0] w_shift;
  logic [15:0] w_bcd;
  logic [1:0]  w_idx_next;
  logic [3:0]  w_digit;
  logic [3:0]  w_blank;

  assign w_sat = (r_number_q > 14'd9999) ? 14'd9999 : r_number_q;

  // Double dabble: correct each BCD nibble >= 5 before every shift.
  always_comb begin
    w_shift = {16'd0, w_sat};
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (w_shift[14+4*k +: 4] >= 4'd5)
          w_shift[14+4*k +: 4] = w_shift[14+4*k +: 4] + 4'd3;
      end
      w_shift = w_shift << 1;
    end
  end

  assign w_bcd = w_shift[29:14];

  assign w_idx_next = (r_cnt == LAST) ? r_idx + 2'd1 : r_idx;

  always_comb begin
    w_digit = w_bcd[3:0];
    case (w_idx_next)
      2'd0: w_digit = w_bcd[3:0];
      2'd1: w_digit = w_bcd[7:4];
      2'd2: w_digit = w_bcd[11:8];
      2'd3: w_digit = w_bcd[15:12];
      default: w_digit = w_bcd[3:0];
    endcase
  end

`ifdef BCD_MUX_LEADING_ZERO_BLANK_EN
  // A digit is blanked only if it and every higher digit are zero; ones never blanks.
  assign w_blank[3] = (w_bcd[15:12] == 4'd0);
  assign w_blank[2] = w_blank[3] && (w_bcd[11:8] == 4'd0);
  assign w_blank[1] = w_blank[2] && (w_bcd[7:4] == 4'd0);
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = 4'b0000;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_number_q    <= 14'd0;
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      output_number <= 4'd0;
      digit_select  <= 4'b1110;
    end else begin
      r_number_q <= number;
      r_cnt      <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_idx      <= w_idx_next;
      if (w_blank[w_idx_next]) begin
        output_number <= 4'd0;
        digit_select  <= 4'b1111;
      end else begin
        output_number <= w_digit;
        digit_select  <= ~(4'b0001 << w_idx_next);
      end
    end
  end

endmodule

// File: tb/tb_bcd_mux.sv
// Randomized bench for bcd_mux against a time/arithmetic reference model, plus literal pins.
module tb_bcd_mux;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] number = 14'd0;
  logic [3:0]  output_number;
  logic [3:0]  digit_select;

  int n_chk = 0;
  int n_fail = 0;

  bcd_mux #(.REFRESH_OVERFLOW(N)) dut (
    .clk(clk), .reset(reset), .number(number),
    .output_number(output_number), .digit_select(digit_select)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
  endfunction

  function automatic logic [3:0] exp_digit(input int v, input int idx);
    int s;
    s = (v > 9999) ? 9999 : v;
`ifdef BCD_MUX_LEADING_ZERO_BLANK_EN
    if (idx > 0 && s < pow10(idx)) return 4'd0;
`endif
    return 4'((s / pow10(idx)) % 10);
  endfunction

  function automatic logic [3:0] exp_sel(input int v, input int idx);
    int s;
    s = (v > 9999) ? 9999 : v;
`ifdef BCD_MUX_LEADING_ZERO_BLANK_EN
    if (idx > 0 && s < pow10(idx)) return 4'hF;
`endif
    return 4'hF ^ (4'h1 << idx);
  endfunction

  // Model: slot index is (clocks since reset release / N) mod 4; value shown is number from two edges back.
  int         m_e = 0;
  int         m_q = 0;
  int         m_idx = 0;
  logic [3:0] m_num = 4'd0;
  logic [3:0] m_sel = 4'b1110;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_e = 0; m_q = 0; m_idx = 0; m_num = 4'd0; m_sel = 4'b1110;
    end else begin
      m_e++;
      m_idx = (m_e / N) % 4;
      m_num = exp_digit(m_q, m_idx);
      m_sel = exp_sel(m_q, m_idx);
      m_q   = int'(number);
    end
  end

  always @(negedge clk) begin
    n_chk++;
    if (output_number !== m_num || digit_select !== m_sel || output_number > 4'd9) begin
      n_fail++;
      $display("FAIL scan t=%0t: got num=%0d sel=%b, want num=%0d sel=%b", $time,
               output_number, digit_select, m_num, m_sel);
    end
  end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  logic [3:0] obs_num [4];
  logic [3:0] obs_sel [4];

  task automatic capture(input int v);
    number = 14'(v);
    repeat (3) @(negedge clk);
    repeat (4 * N) begin
      @(negedge clk); #1;
      obs_num[m_idx] = output_number;
      obs_sel[m_idx] = digit_select;
    end
  endtask

  task automatic chk_digits(input string nm, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    chk({nm, "_d0"}, obs_num[0], d0);
    chk({nm, "_d1"}, obs_num[1], d1);
    chk({nm, "_d2"}, obs_num[2], d2);
    chk({nm, "_d3"}, obs_num[3], d3);
  endtask

  task automatic run_len(output logic [3:0] sel, output int len);
    sel = digit_select;
    len = 0;
    while (digit_select == sel && len < 100) begin
      len++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] sel;
    logic [3:0] prev;
    logic [3:0] want_sel [5];
    int len;
    int found;
    want_sel[0] = 4'b1110; want_sel[1] = 4'b1101; want_sel[2] = 4'b1011;
    want_sel[3] = 4'b0111; want_sel[4] = 4'b1110;

    // Reset held
    repeat (3) @(negedge clk);
    #1;
    chk("reset_num", output_number, 4'd0);
    chk("reset_sel", digit_select, 4'b1110);
    @(negedge clk);
    reset = 1'b0;

    // Constant 1234: digit values and slot order/length
    capture(1234);
    chk_digits("n1234", 4'd1, 4'd2, 4'd3, 4'd4);
    chk("n1234_sel0", obs_sel[0], 4'b1110);
    chk("n1234_sel3", obs_sel[3], 4'b0111);
    prev = digit_select;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk); #1;
      if (digit_select == 4'b1110 && prev != 4'b1110) found = 1;
      prev = digit_select;
    end
    chk_int("align_found", found, 1);
    for (int s = 0; s < 5; s++) begin
      run_len(sel, len);
      chk("order_sel", sel, want_sel[s]);
      chk_int("slot_len", len, N);
    end

    // Boundaries
    capture(9999);  chk_digits("n9999", 4'd9, 4'd9, 4'd9, 4'd9);
    capture(10000); chk_digits("n10000", 4'd9, 4'd9, 4'd9, 4'd9);
    capture(16383); chk_digits("n16383", 4'd9, 4'd9, 4'd9, 4'd9);
    capture(1000);  chk_digits("n1000", 4'd1, 4'd0, 4'd0, 4'd0);
    chk("n1000_sel3", obs_sel[3], 4'b0111);
`ifdef BCD_MUX_LEADING_ZERO_BLANK_EN
    capture(42);
    chk("n42_d0", obs_num[0], 4'd2);
    chk("n42_sel0", obs_sel[0], 4'b1110);
    chk("n42_d1", obs_num[1], 4'd4);
    chk("n42_sel1", obs_sel[1], 4'b1101);
    chk("n42_sel2", obs_sel[2], 4'b1111);
    chk("n42_sel3", obs_sel[3], 4'b1111);
    capture(0);
    chk("n0_d0", obs_num[0], 4'd0);
    chk("n0_sel0", obs_sel[0], 4'b1110);
    chk("n0_sel1", obs_sel[1], 4'b1111);
    chk("n0_sel3", obs_sel[3], 4'b1111);
`else
    capture(0);     chk_digits("n0", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("n0_sel2", obs_sel[2], 4'b1011);
`endif

    // Ramp 1..100, one step every 2 clocks
    for (int v = 1; v <= 100; v++) begin
      number = 14'(v);
      repeat (2) @(negedge clk);
    end

    // Async reset mid digit-2 slot
    number = 14'd5678;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (m_idx == 2) found = 1;
    end
    chk_int("slot2_found", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_num", output_number, 4'd0);
    chk("midrst_sel", digit_select, 4'b1110);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    len = 0;
    while (digit_select == 4'b1110 && len < 100) begin
      len++;
      @(negedge clk); #1;
    end
    chk_int("rst_slot0_len", len, N);

    // Randomized values, biased around the saturation point
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        number = 14'($urandom_range(9990, 10010));
      else
        number = 14'($urandom_range(0, 16383));
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
